// File: rtl/gs_pkg.sv
// Shared definitions for the 16-unknown Gauss-Seidel solver: row sizing, sequencer
// states and the interleaved row order used by the sequencer and the b/x stores.
package gs_pkg;

  localparam int N_ROWS = 16;
  localparam int ROW_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } gs_state_t;

  // Swapping the index halves spreads consecutive issues across the four row
  // groups, so back-to-back updates never depend on each other's result.
  function automatic logic [ROW_W-1:0] row_of(input logic [ROW_W-1:0] c);
    return {c[1:0], c[3:2]};
  endfunction

endpackage

// File: rtl/gs_wb_delay.sv
// Write-back delay line: carries {valid, row} through DEPTH registers so the
// write-back strobe lines up with the datapath result.
module gs_wb_delay
  import gs_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             in_vld,
  input  logic [ROW_W-1:0] in_idx,
  output logic             out_vld,
  output logic [ROW_W-1:0] out_idx
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][ROW_W-1:0] idx_pipe;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      idx_pipe[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH-1];
  assign out_idx = idx_pipe[DEPTH-1];

endmodule

// File: rtl/gs_sweep_sequencer.sv
// Gauss-Seidel sweep sequencer: counts the b load, issues interleaved rows for a
// fixed or converged number of sweeps, drains the datapath, then streams x out.
module gs_sweep_sequencer
  import gs_pkg::*;
#(
  parameter int MAX_SWEEP = 70,
  parameter int PIPE_LAT  = 1,
  parameter int SWEEP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               in_en,
  input  logic               conv_in,
  output logic               b_shift,
  output logic               cu_issue,
  output logic [ROW_W-1:0]   row_idx,
  output logic               wb_en,
  output logic [ROW_W-1:0]   wb_idx,
  output logic               out_valid,
  output logic [ROW_W-1:0]   out_idx,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               busy
);

  localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(N_ROWS - 1);
  localparam logic [1:0]         DRAIN_LAST  = 2'(PIPE_LAT - 1);
  localparam logic [SWEEP_W-1:0] SWEEP_LIMIT = SWEEP_W'(MAX_SWEEP);

  gs_state_t          state;
  logic [ROW_W-1:0]   ld_cnt;
  logic [ROW_W-1:0]   iss_cnt;
  logic [ROW_W-1:0]   out_cnt;
  logic [1:0]         dr_cnt;
  logic [SWEEP_W-1:0] sweep_nxt;
  logic               accept;

  assign sweep_nxt = sweep_cnt + 1'b1;
  assign accept    = in_en && (state == ST_IDLE || state == ST_LOAD);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      ld_cnt    <= '0;
      iss_cnt   <= '0;
      out_cnt   <= '0;
      dr_cnt    <= '0;
      sweep_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_en) begin
          // the accepting word is load word 0
          state     <= ST_LOAD;
          ld_cnt    <= ROW_W'(1);
          sweep_cnt <= '0;
        end
        ST_LOAD: if (in_en) begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_cnt == LAST_ROW) state <= ST_RUN;
        end
        ST_RUN: begin
          iss_cnt <= iss_cnt + 1'b1;
          if (iss_cnt == LAST_ROW) begin
            sweep_cnt <= sweep_nxt;
            if (sweep_nxt == SWEEP_LIMIT || conv_in) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (dr_cnt == DRAIN_LAST) begin
            dr_cnt <= '0;
            state  <= ST_OUT;
          end else begin
            dr_cnt <= dr_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          out_cnt <= out_cnt + 1'b1;
          if (out_cnt == LAST_ROW) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cu_issue  = (state == ST_RUN);
  assign row_idx   = row_of(iss_cnt);
  assign out_valid = (state == ST_OUT);
  assign out_idx   = out_cnt;
  assign busy      = (state != ST_IDLE);
  // gated so a word held on in_en during reset never strobes the b store
  assign b_shift   = !rst_in && (accept || cu_issue);

  gs_wb_delay #(.DEPTH(PIPE_LAT)) u_wb_delay (
    .clk     (clk),
    .rst_in  (rst_in),
    .in_vld  (cu_issue),
    .in_idx  (row_idx),
    .out_vld (wb_en),
    .out_idx (wb_idx)
  );

endmodule
